fifo_uart_tx_cfg: RTL and testbench

//  Buffered UART transmitter, next generation of the FIFO+UART TX path.

---
 rtl/fifo_uart_tx_cfg.sv | 231 +++++++++++++++++++++++
 tb/tb_fifo_uart_tx_cfg.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx_cfg.sv
// Buffered UART transmitter: circular FIFO with level flags feeding a run-time configurable serializer.
// Optional parity bit is enabled by defining FIFO_UART_TX_CFG_PARITY_EN.
module fifo_uart_tx_cfg #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 128,
    parameter int DIV_W     = 16,
    parameter int MSB_FIRST = 0
) (
    input  logic                       clk,
    input  logic                       i_reset,
    input  logic                       i_tx_enable,
    input  logic                       i_w_en,
    input  logic [WIDTH-1:0]           i_w_data,
    input  logic [DIV_W-1:0]           i_divisor,
    input  logic                       i_stop2,
`ifdef FIFO_UART_TX_CFG_PARITY_EN
    input  logic                       i_par_en,
    input  logic                       i_par_odd,
`endif
    input  logic [$clog2(DEPTH):0]     i_afull_lvl,
    input  logic [$clog2(DEPTH):0]     i_aempty_lvl,
    output logic                       o_tx,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_afull,
    output logic                       o_empty,
    output logic                       o_aempty,
    output logic                       o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef FIFO_UART_TX_CFG_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic [WIDTH-1:0] r_pop_data;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_baud;
    logic [BW-1:0]    r_bit;
    logic             r_stop2;
    logic             r_stop_hi;
    logic             r_tx;
`ifdef FIFO_UART_TX_CFG_PARITY_EN
    logic             r_par_en;
    logic             r_par_bit;
`endif

    logic             w_full;
    logic             w_empty;
    logic             w_can_pop;
    logic             w_last_stop;
    logic             w_pop;
    logic             w_wr;
    logic             w_baud_end;
    logic [DIV_W-1:0] w_div_eff;
    logic             w_data_bit;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_line;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_can_pop   = i_tx_enable && !w_empty;
    assign w_last_stop = !r_stop2 || r_stop_hi;
    assign w_baud_end  = (r_baud == '0);
    assign w_div_eff   = (i_divisor < DIV_W'(2)) ? DIV_W'(2) : i_divisor;

    // Back-to-back frames pop one clock before the stop bit ends so LOAD fills that clock.
    assign w_pop = w_can_pop && ((r_state == S_IDLE) ||
                   ((r_state == S_STOP) && w_last_stop && (r_baud == DIV_W'(1))));
    assign w_wr  = i_w_en && (!w_full || w_pop);

    assign w_data_bit   = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
    assign w_shift_next = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                           : {1'b0, r_shift[WIDTH-1:1]};

    always_comb begin
        w_line = 1'b1;
        case (r_state)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = w_data_bit;
`ifdef FIFO_UART_TX_CFG_PARITY_EN
            S_PARITY: w_line = r_par_bit;
`endif
            default:  w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= i_w_data;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_pop_data <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_pop_data <= r_mem[r_rd_ptr];
            end
            if (w_wr && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_wr)
                r_count <= r_count - CW'(1);
            if (i_w_en && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_div     <= DIV_W'(2);
            r_baud    <= '0;
            r_bit     <= '0;
            r_stop2   <= 1'b0;
            r_stop_hi <= 1'b0;
            r_tx      <= 1'b1;
`ifdef FIFO_UART_TX_CFG_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
`endif
        end else begin
            r_tx <= w_line;
            case (r_state)
                S_IDLE: begin
                    if (w_can_pop)
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift   <= r_pop_data;
                    r_div     <= w_div_eff;
                    r_baud    <= w_div_eff - DIV_W'(1);
                    r_stop2   <= i_stop2;
                    r_stop_hi <= 1'b0;
                    r_bit     <= '0;
`ifdef FIFO_UART_TX_CFG_PARITY_EN
                    r_par_en  <= i_par_en;
                    r_par_bit <= (^r_pop_data) ^ i_par_odd;
`endif
                    r_state   <= S_START;
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= r_div - DIV_W'(1);
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud - DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud  <= r_div - DIV_W'(1);
                        r_shift <= w_shift_next;
                        if (r_bit == BW'(WIDTH - 1)) begin
                            r_bit <= '0;
`ifdef FIFO_UART_TX_CFG_PARITY_EN
                            r_state <= r_par_en ? S_PARITY : S_STOP;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end else begin
                        r_baud <= r_baud - DIV_W'(1);
                    end
                end
`ifdef FIFO_UART_TX_CFG_PARITY_EN
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= r_div - DIV_W'(1);
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud - DIV_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_pop) begin
                        r_state <= S_LOAD;
                    end else if (w_baud_end) begin
                        if (!w_last_stop) begin
                            r_stop_hi <= 1'b1;
                            r_baud    <= r_div - DIV_W'(1);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - DIV_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tx       = r_tx;
    assign o_busy     = (r_state != S_IDLE);
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_afull    = (r_count >= i_afull_lvl);
    assign o_aempty   = (r_count <= i_aempty_lvl);
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_fifo_uart_tx_cfg.sv
// Randomized bench for fifo_uart_tx_cfg: expected line waveform is built from each word's frame layout.
`timescale 1ns/1ps
module tb_fifo_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        w_en;
    logic [7:0]  w_data;
    logic [15:0] div;
    logic        stop2;
    logic [3:0]  afl;
    logic [3:0]  ael;
`ifdef FIFO_UART_TX_CFG_PARITY_EN
    logic        par_en = 1'b0;
    logic        par_odd = 1'b0;
`endif
    logic        o_tx, o_busy, o_full, o_afull, o_empty, o_aempty, o_overflow;
    logic [3:0]  o_count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [7:0]  mq[$];

    fifo_uart_tx_cfg #(.WIDTH(8), .DEPTH(8), .DIV_W(16), .MSB_FIRST(0)) dut (
        .clk(clk), .i_reset(rst), .i_tx_enable(en), .i_w_en(w_en), .i_w_data(w_data),
        .i_divisor(div), .i_stop2(stop2),
`ifdef FIFO_UART_TX_CFG_PARITY_EN
        .i_par_en(par_en), .i_par_odd(par_odd),
`endif
        .i_afull_lvl(afl), .i_aempty_lvl(ael),
        .o_tx(o_tx), .o_busy(o_busy), .o_count(o_count), .o_full(o_full), .o_afull(o_afull),
        .o_empty(o_empty), .o_aempty(o_aempty), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Writes one word on the next rising edge; returns at the following falling edge.
    task automatic push(input logic [7:0] d);
        w_en = 1'b1;
        w_data = d;
        @(negedge clk);
        w_en = 1'b0;
        if (mq.size() < 8) mq.push_back(d);
    endtask

    task automatic expect_frame(input logic [7:0] word, input int d, input bit s2,
                                input bit pe, input bit po, input int max_wait, input string tag);
        bit q[$];
        int dv;
        bit seen;
        dv = (d < 2) ? 2 : d;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(word[i]);
        if (pe) q.push_back((^word) ^ po);
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        seen = 1'b0;
        for (int w = 0; w <= max_wait; w++) begin
            @(negedge clk);
            if (o_tx == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_start"}, 32'(seen), 32'd1);
        if (!seen) return;
        for (int c = 1; c < q.size() * dv; c++) begin
            @(negedge clk);
            check(tag, 32'(o_tx), 32'(q[c / dv]));
        end
    endtask

    task automatic drain(input int d, input bit s2, input string tag);
        int n;
        n = mq.size();
        for (int k = 0; k < n; k++) begin
            logic [7:0] x;
            x = mq.pop_front();
            expect_frame(x, d, s2, 1'b0, 1'b0, (k == 0) ? 3 : 0, tag);
        end
    endtask

    initial begin
        logic [7:0] a, b;
        int lows;
        rst = 1'b1; en = 1'b0; w_en = 1'b0; w_data = '0;
        div = 16'd4; stop2 = 1'b0; afl = 4'd6; ael = 4'd2;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(o_tx), 1);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_count", 32'(o_count), 0);
        check("rst_empty", 32'(o_empty), 1);
        check("rst_aempty", 32'(o_aempty), 1);
        check("rst_full", 32'(o_full), 0);
        check("rst_afull", 32'(o_afull), 0);
        check("rst_ovf", 32'(o_overflow), 0);
        rst = 1'b0;
        @(negedge clk);

        // single frame and N+3 latency
        en = 1'b1;
        push(8'hA5);
        void'(mq.pop_front());
        check("lat_n0", 32'(o_tx), 1);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            check("lat_idle", 32'(o_tx), 1);
        end
        expect_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0, 0, "single");
        @(negedge clk);
        check("single_busy_end", 32'(o_busy), 0);
        check("single_tx_end", 32'(o_tx), 1);

        // fill past full with transmitter held off
        en = 1'b0;
        for (int i = 0; i < 9; i++) push(8'($urandom));
        check("fill_count", 32'(o_count), 8);
        check("fill_full", 32'(o_full), 1);
        check("fill_ovf", 32'(o_overflow), 1);
        check("fill_empty", 32'(o_empty), 0);
        en = 1'b1;
        drain(4, 1'b0, "fill_frame");
        @(negedge clk);
        check("fill_drained", 32'(o_empty), 1);
        check("fill_busy", 32'(o_busy), 0);
        check("fill_ovf_sticky", 32'(o_overflow), 1);

        // reset mid-frame
        en = 1'b0;
        for (int i = 0; i < 3; i++) push(8'($urandom));
        en = 1'b1;
        lows = 0;
        for (int i = 0; i < 20 && lows == 0; i++) begin
            @(negedge clk);
            if (o_tx == 1'b0) lows = 1;
        end
        check("rst_mid_started", 32'(lows), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", 32'(o_tx), 1);
        check("rst_mid_busy", 32'(o_busy), 0);
        check("rst_mid_count", 32'(o_count), 0);
        check("rst_mid_empty", 32'(o_empty), 1);
        check("rst_mid_ovf", 32'(o_overflow), 0);
        rst = 1'b0;
        mq.delete();

        // two stop bits, divisor change mid-frame, divisor floor
        div = 16'd3; stop2 = 1'b1;
        a = 8'($urandom);
        push(a); void'(mq.pop_front());
        expect_frame(a, 3, 1'b1, 1'b0, 1'b0, 3, "stop2");
        stop2 = 1'b0; en = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        push(a); push(b); mq.delete();
        en = 1'b1;
        fork
            begin
                expect_frame(a, 3, 1'b0, 1'b0, 1'b0, 3, "div_old");
                expect_frame(b, 5, 1'b0, 1'b0, 1'b0, 0, "div_new");
            end
            begin
                repeat (6) @(negedge clk);
                div = 16'd5;
            end
        join
        div = 16'd0;
        a = 8'($urandom);
        push(a); void'(mq.pop_front());
        expect_frame(a, 0, 1'b0, 1'b0, 1'b0, 3, "div_min");

        // disabling mid-frame completes the frame, then holds idle
        en = 1'b0; div = 16'd2;
        a = 8'($urandom); b = 8'($urandom);
        push(a); push(b); mq.delete();
        en = 1'b1;
        fork
            expect_frame(a, 2, 1'b0, 1'b0, 1'b0, 3, "en_off_frame");
            begin
                repeat (4) @(negedge clk);
                en = 1'b0;
            end
        join
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_tx == 1'b0) lows++;
        end
        check("en_off_hold", 32'(lows), 0);
        check("en_off_count", 32'(o_count), 1);
        en = 1'b1;
        expect_frame(b, 2, 1'b0, 1'b0, 1'b0, 3, "en_on_frame");

        // level flags, then write+pop while full
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        en = 1'b0; div = 16'd2; afl = 4'd6; ael = 4'd2;
        for (int k = 1; k <= 8; k++) begin
            push(8'($urandom));
            check("lvl_count", 32'(o_count), 32'(k));
            check("lvl_afull", 32'(o_afull), 32'(k >= 6));
            check("lvl_aempty", 32'(o_aempty), 32'(k <= 2));
            check("lvl_full", 32'(o_full), 32'(k == 8));
        end
        en = 1'b1;
        a = 8'($urandom);
        w_en = 1'b1; w_data = a;
        @(negedge clk);
        w_en = 1'b0;
        mq.push_back(a);
        check("wp_full_count", 32'(o_count), 8);
        check("wp_full_ovf", 32'(o_overflow), 0);
        begin
            logic [7:0] x;
            x = mq.pop_front();
            expect_frame(x, 2, 1'b0, 1'b0, 1'b0, 2, "wp_frame");
            for (int k = 0; k < 8; k++) begin
                x = mq.pop_front();
                expect_frame(x, 2, 1'b0, 1'b0, 1'b0, 0, "wp_frame");
            end
        end

        // randomized batches with random configuration and thresholds
        for (int it = 0; it < 6; it++) begin
            int n;
            @(negedge clk);
            en = 1'b0;
            div = 16'($urandom_range(0, 5));
            stop2 = 1'($urandom);
            afl = 4'($urandom_range(0, 8));
            ael = 4'($urandom_range(0, 8));
            n = $urandom_range(1, 8);
            for (int k = 1; k <= n; k++) begin
                push(8'($urandom));
                check("rnd_count", 32'(o_count), 32'(k));
                check("rnd_afull", 32'(o_afull), 32'(k >= int'(afl)));
                check("rnd_aempty", 32'(o_aempty), 32'(k <= int'(ael)));
            end
            en = 1'b1;
            drain(int'(div), stop2, "rnd_frame");
            @(negedge clk);
            check("rnd_empty", 32'(o_empty), 1);
        end

`ifdef FIFO_UART_TX_CFG_PARITY_EN
        div = 16'd2; stop2 = 1'b0;
        par_en = 1'b1; par_odd = 1'b0;
        push(8'hA5); void'(mq.pop_front());
        expect_frame(8'hA5, 2, 1'b0, 1'b1, 1'b0, 3, "par_even");
        par_odd = 1'b1;
        push(8'hA5); void'(mq.pop_front());
        expect_frame(8'hA5, 2, 1'b0, 1'b1, 1'b1, 3, "par_odd");
        par_en = 1'b0;
        push(8'hA5); void'(mq.pop_front());
        expect_frame(8'hA5, 2, 1'b0, 1'b0, 1'b0, 3, "par_off");
        @(negedge clk);
        check("par_off_idle", 32'(o_tx), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
